usb_rx_packet_scheduler: RTL and testbench

Round-robin packet scheduler for the USB receive path, clocked on usbclk. It selects which channel buffer (sample channels 0..NUM_CHAN-1, command/status channel NUM_CHAN) supplies the next 512-byte packet to the FX2. It announces the packet to the FX2, gates the FX2 read strobe into per-channel pop strobes for exactly one packet, then signals packet completion to the owning buffer.

---
 rtl/usb_rx_packet_scheduler_if.sv | 35 +++
 rtl/usb_rx_packet_scheduler.sv | 131 +++++++++++++
 tb/tb_usb_rx_packet_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_packet_scheduler_if.sv
// Bus between the USB receive scheduler, the per-channel packet buffers and the FX2 read port.
// Also carries read-only debug views of the scheduler FSM and its word counter.
interface usb_rx_packet_scheduler_if #(
  parameter int NUM_CHAN  = 2,
  parameter int PKT_WORDS = 256
);
  localparam int NR  = NUM_CHAN + 1;
  localparam int WCW = $clog2(PKT_WORDS) + 1;

  // Handshake: have_pkt_rdy is the valid for a whole packet and RD_fx2 is the per-word ready.
  // A word transfers on every cycle rd_en_channel[i] is high. RD_fx2 outside a packet is
  // never a transfer and only bumps overrun_count. rd_done_channel closes the packet.
  logic [NR-1:0]  pkt_waiting;
  logic           RD_fx2;
  logic           have_pkt_rdy;
  logic [NR-1:0]  rd_en_channel;
  logic [NR-1:0]  rd_done_channel;
  logic [4:0]     grant_chan;
  logic           busy;
  logic [7:0]     overrun_count;
  logic [2:0]     dbg_state;
  logic [WCW-1:0] dbg_word_count;

  modport master (
    output pkt_waiting, RD_fx2,
    input  have_pkt_rdy, rd_en_channel, rd_done_channel, grant_chan, busy,
           overrun_count, dbg_state, dbg_word_count
  );

  modport slave (
    input  pkt_waiting, RD_fx2,
    output have_pkt_rdy, rd_en_channel, rd_done_channel, grant_chan, busy,
           overrun_count, dbg_state, dbg_word_count
  );
endinterface

// File: rtl/usb_rx_packet_scheduler.sv
// Round-robin scheduler choosing which channel buffer feeds the next packet to the FX2,
// gating RD_fx2 into per-channel pops for exactly one packet and then pulsing rd_done.
module usb_rx_packet_scheduler #(
  parameter int NUM_CHAN  = 2,
  parameter int PKT_WORDS = 256
) (
  input logic                     usbclk,
  input logic                     reset,
  usb_rx_packet_scheduler_if.slave bus
);
   localparam int NR  = NUM_CHAN + 1;
   localparam int WCW = $clog2(PKT_WORDS) + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ARB    = 3'd1;
   localparam logic [2:0] S_READY  = 3'd2;
   localparam logic [2:0] S_STREAM = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]     state;
   logic [4:0]     grant_chan;
   logic [4:0]     last_grant;
   logic [WCW-1:0] word_count;
   logic           have_pkt_rdy;
   logic           busy;
   logic [7:0]     overrun_count;
   logic [NR-1:0]  rd_done_channel;
   logic [NR-1:0]  rd_en_channel;
   logic           pop_state;
   logic           arb_found;
   logic [4:0]     arb_idx;

   assign pop_state = (state == S_READY) || (state == S_STREAM);

   // Second pass (channels above last_grant) overrides the wrap-around pass; descending
   // loops leave the lowest matching index in each pass.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int j = NR - 1; j >= 0; j--) begin
         if (bus.pkt_waiting[j] && (5'(j) <= last_grant)) begin
            arb_found = 1'b1;
            arb_idx   = 5'(j);
         end
      end
      for (int j = NR - 1; j >= 0; j--) begin
         if (bus.pkt_waiting[j] && (5'(j) > last_grant)) begin
            arb_found = 1'b1;
            arb_idx   = 5'(j);
         end
      end
   end

   // Gated by reset so a buffer is never popped in the cycle its packet is abandoned.
   always_comb begin
      rd_en_channel = '0;
      for (int j = 0; j < NR; j++) begin
         rd_en_channel[j] = bus.RD_fx2 && pop_state && !reset && (grant_chan == 5'(j));
      end
   end

   always_ff @(posedge usbclk) begin
      if (reset) begin
         state           <= S_IDLE;
         grant_chan      <= '0;
         last_grant      <= 5'(NUM_CHAN);
         word_count      <= '0;
         have_pkt_rdy    <= 1'b0;
         busy            <= 1'b0;
         overrun_count   <= '0;
         rd_done_channel <= '0;
      end else begin
         rd_done_channel <= '0;
         if (bus.RD_fx2 && !pop_state && (overrun_count != 8'hFF)) begin
            overrun_count <= overrun_count + 8'd1;
         end
         case (state)
            S_IDLE: begin
               if (|bus.pkt_waiting) state <= S_ARB;
            end
            S_ARB: begin
               if (arb_found) begin
                  grant_chan   <= arb_idx;
                  word_count   <= '0;
                  have_pkt_rdy <= 1'b1;
                  busy         <= 1'b1;
                  state        <= S_READY;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_READY: begin
               if (bus.RD_fx2) begin
                  word_count   <= WCW'(1);
                  have_pkt_rdy <= 1'b0;
                  if (PKT_WORDS == 1) begin
                     state <= S_DONE;
                     for (int j = 0; j < NR; j++) rd_done_channel[j] <= (grant_chan == 5'(j));
                  end else begin
                     state <= S_STREAM;
                  end
               end
            end
            S_STREAM: begin
               if (bus.RD_fx2) begin
                  word_count <= word_count + WCW'(1);
                  if (word_count == WCW'(PKT_WORDS - 1)) begin
                     state <= S_DONE;
                     for (int j = 0; j < NR; j++) rd_done_channel[j] <= (grant_chan == 5'(j));
                  end
               end
            end
            S_DONE: begin
               last_grant <= grant_chan;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.have_pkt_rdy    = have_pkt_rdy;
   assign bus.rd_en_channel   = rd_en_channel;
   assign bus.rd_done_channel = rd_done_channel;
   assign bus.grant_chan      = grant_chan;
   assign bus.busy            = busy;
   assign bus.overrun_count   = overrun_count;
   assign bus.dbg_state       = state;
   assign bus.dbg_word_count  = word_count;
endmodule

// File: tb/tb_usb_rx_packet_scheduler.sv
// Directed bench for usb_rx_packet_scheduler: single packet, round robin, stalls,
// overrun saturation, mid-packet reset and a withdrawn request.
module tb_usb_rx_packet_scheduler;
  localparam int NUM_CHAN  = 2;
  localparam int PKT_WORDS = 256;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARB    = 3'd1;
  localparam logic [2:0] S_READY  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic usbclk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   cyc;

  usb_rx_packet_scheduler_if #(.NUM_CHAN(NUM_CHAN), .PKT_WORDS(PKT_WORDS)) bus ();

  usb_rx_packet_scheduler #(.NUM_CHAN(NUM_CHAN), .PKT_WORDS(PKT_WORDS)) dut (
    .usbclk (usbclk),
    .reset  (reset),
    .bus    (bus)
  );

  // clock / reset
  initial usbclk = 1'b0;
  always #5 usbclk = ~usbclk;

  function automatic logic [2:0] oh(input int c);
    logic [2:0] one;
    one = 3'b001;
    return one << c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge usbclk);
    reset = 1'b1;
    @(negedge usbclk);
    @(negedge usbclk);
    reset = 1'b0;
  endtask

  // Steps negedges until have_pkt_rdy is seen; cycles counts edges from the call.
  task automatic wait_ready(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge usbclk);
      cycles++;
    end while (!bus.have_pkt_rdy && cycles < 20);
    check(tag, 32'(bus.have_pkt_rdy), 32'd1);
  endtask

  // Reads one full packet from chan; ends on the negedge inside the DONE cycle.
  task automatic read_packet(input string tag, input int chan, input bit stall, input int drop_after);
    int  pops, highs, bad, wc_bad, guard;
    bit  rd, phase;
    pops = 0; highs = 0; bad = 0; wc_bad = 0; guard = 0; phase = 1'b0;
    while (highs < PKT_WORDS && guard < 4 * PKT_WORDS) begin
      @(negedge usbclk);
      if (drop_after >= 0 && highs == drop_after) bus.pkt_waiting = '0;
      rd = stall ? ~phase : 1'b1;
      phase = ~phase;
      if (!rd && bus.dbg_word_count != 9'(highs)) wc_bad++;
      if (bus.dbg_state == S_DONE || bus.rd_done_channel != 3'b000) bad++;
      bus.RD_fx2 = rd;
      #1;
      if (rd) begin
        if (bus.rd_en_channel == oh(chan)) pops++;
        else bad++;
        highs++;
      end else if (bus.rd_en_channel != 3'b000) begin
        bad++;
      end
      guard++;
    end
    @(negedge usbclk);
    bus.RD_fx2 = 1'b0;
    #1;
    check({tag, "_pops"}, 32'(pops), 32'(PKT_WORDS));
    check({tag, "_strobe_errs"}, 32'(bad), 32'd0);
    if (stall) check({tag, "_wc_frozen_errs"}, 32'(wc_bad), 32'd0);
    check({tag, "_done_pulse"}, 32'(bus.rd_done_channel), 32'(oh(chan)));
    check({tag, "_state_done"}, 32'(bus.dbg_state), 32'(S_DONE));
    check({tag, "_rdy_low"}, 32'(bus.have_pkt_rdy), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.pkt_waiting = '0;
    bus.RD_fx2      = 1'b1;
    @(negedge usbclk);
    #1;
    check("rst_rd_en", 32'(bus.rd_en_channel), 32'd0);
    @(negedge usbclk);
    check("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    check("rst_rdy", 32'(bus.have_pkt_rdy), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_grant", 32'(bus.grant_chan), 32'd0);
    check("rst_overrun", 32'(bus.overrun_count), 32'd0);
    check("rst_done", 32'(bus.rd_done_channel), 32'd0);
    check("rst_wc", 32'(bus.dbg_word_count), 32'd0);
    bus.RD_fx2 = 1'b0;
    reset      = 1'b0;

    // single packet on channel 0, with request-to-announce timing
    @(negedge usbclk);
    bus.pkt_waiting = 3'b001;
    @(negedge usbclk);
    check("single_arb_state", 32'(bus.dbg_state), 32'(S_ARB));
    check("single_arb_rdy", 32'(bus.have_pkt_rdy), 32'd0);
    @(negedge usbclk);
    check("single_ready_state", 32'(bus.dbg_state), 32'(S_READY));
    check("single_rdy", 32'(bus.have_pkt_rdy), 32'd1);
    check("single_busy", 32'(bus.busy), 32'd1);
    check("single_grant", 32'(bus.grant_chan), 32'd0);
    bus.pkt_waiting = '0;
    read_packet("single", 0, 1'b0, -1);
    check("single_busy_done", 32'(bus.busy), 32'd1);
    @(negedge usbclk);
    check("single_done_clear", 32'(bus.rd_done_channel), 32'd0);
    check("single_idle", 32'(bus.dbg_state), 32'(S_IDLE));
    check("single_busy_idle", 32'(bus.busy), 32'd0);
    check("single_rdy_after", 32'(bus.have_pkt_rdy), 32'd0);

    // round robin with all requests held: 0,1,2,0
    do_reset();
    bus.pkt_waiting = 3'b111;
    wait_ready("rr0_ready", cyc);
    check("rr0_latency", 32'(cyc), 32'd2);
    check("rr0_grant", 32'(bus.grant_chan), 32'd0);
    read_packet("rr0", 0, 1'b0, -1);
    wait_ready("rr1_ready", cyc);
    check("rr1_b2b_latency", 32'(cyc), 32'd3);
    check("rr1_grant", 32'(bus.grant_chan), 32'd1);
    read_packet("rr1", 1, 1'b0, -1);
    wait_ready("rr2_ready", cyc);
    check("rr2_grant", 32'(bus.grant_chan), 32'd2);
    read_packet("rr2", 2, 1'b0, -1);
    wait_ready("rr3_ready", cyc);
    check("rr3_grant", 32'(bus.grant_chan), 32'd0);
    bus.pkt_waiting = '0;
    read_packet("rr3", 0, 1'b0, -1);

    // stalled read on channel 1 (last grant was 0)
    bus.pkt_waiting = 3'b010;
    wait_ready("stall_ready", cyc);
    check("stall_grant", 32'(bus.grant_chan), 32'd1);
    bus.pkt_waiting = '0;
    read_packet("stall", 1, 1'b1, -1);

    // overrun: RD_fx2 with nothing granted
    do_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge usbclk);
      if (i == 100) check("overrun_mid", 32'(bus.overrun_count), 32'd100);
      bus.RD_fx2 = 1'b1;
      #1;
      if (bus.rd_en_channel != 3'b000) check("overrun_rd_en", 32'(bus.rd_en_channel), 32'd0);
    end
    @(negedge usbclk);
    bus.RD_fx2 = 1'b0;
    check("overrun_sat", 32'(bus.overrun_count), 32'd255);
    check("overrun_state", 32'(bus.dbg_state), 32'(S_IDLE));

    // mid-packet reset after 100 pops on channel 1
    do_reset();
    bus.pkt_waiting = 3'b010;
    wait_ready("mid_ready", cyc);
    check("mid_grant", 32'(bus.grant_chan), 32'd1);
    for (int i = 0; i < 100; i++) begin
      @(negedge usbclk);
      bus.RD_fx2 = 1'b1;
    end
    @(negedge usbclk);
    check("mid_wc_100", 32'(bus.dbg_word_count), 32'd100);
    reset = 1'b1;
    #1;
    check("mid_rd_en_in_reset", 32'(bus.rd_en_channel), 32'd0);
    @(negedge usbclk);
    check("mid_state", 32'(bus.dbg_state), 32'(S_IDLE));
    check("mid_rdy", 32'(bus.have_pkt_rdy), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_grant_zero", 32'(bus.grant_chan), 32'd0);
    check("mid_wc", 32'(bus.dbg_word_count), 32'd0);
    check("mid_done", 32'(bus.rd_done_channel), 32'd0);
    check("mid_rd_en", 32'(bus.rd_en_channel), 32'd0);
    reset      = 1'b0;
    bus.RD_fx2 = 1'b0;
    bus.pkt_waiting = 3'b011;
    @(negedge usbclk);
    check("mid_no_done", 32'(bus.rd_done_channel), 32'd0);
    wait_ready("mid_next_ready", cyc);
    check("mid_next_grant", 32'(bus.grant_chan), 32'd0);
    bus.pkt_waiting = '0;
    read_packet("mid_next", 0, 1'b0, -1);

    // request withdrawn after word 10 on channel 2
    bus.pkt_waiting = 3'b100;
    wait_ready("wd_ready", cyc);
    check("wd_grant", 32'(bus.grant_chan), 32'd2);
    read_packet("wd", 2, 1'b0, 10);
    @(negedge usbclk);
    check("wd_idle", 32'(bus.dbg_state), 32'(S_IDLE));
    @(negedge usbclk);
    check("wd_stays_idle", 32'(bus.dbg_state), 32'(S_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
